// File: rtl/pixel_write_master_if.sv
// pixel_write_master_if: pixel input stream plus the Avalon-MM write bus of pixel_write_master.
// The master modport is the pixel_write_master side; slave is the upstream source / adapter side.
interface pixel_write_master_if #(
    parameter int COORD_W = 10
);
    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic [31:0]        in_color;
    logic [25:0]        avm_address;
    logic               avm_write;
    logic [31:0]        avm_writedata;
    logic               avm_waitrequest;

    modport master (
        input  in_valid, in_x, in_y, in_color, avm_waitrequest,
        output in_ready, avm_address, avm_write, avm_writedata
    );

    modport slave (
        output in_valid, in_x, in_y, in_color, avm_waitrequest,
        input  in_ready, avm_address, avm_write, avm_writedata
    );
endinterface

// File: rtl/pixel_write_master.sv
// pixel_write_master: buffers rasterised pixels in a small FIFO and issues one 32-bit Avalon-MM
// write per pixel at base_addr + (y*FB_WIDTH + x)*4. Define CLIP_EN to drop off-screen pixels.
module pixel_write_master #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int COORD_W    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    pixel_write_master_if.master bus,
    input  logic [25:0]          base_addr,
    output logic                 busy,
    output logic [31:0]          pixels_written,
    output logic [15:0]          clipped_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN_FIRST,
        DRAIN
    } state_t;

    // An empty block that only elaborates on a bad configuration, making it visible in the hierarchy.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FB_WIDTH < 1 || FB_HEIGHT < 1)
    begin : g_bad_config
    end

    state_t             state;
    logic [COORD_W-1:0] fifo_x     [FIFO_DEPTH];
    logic [COORD_W-1:0] fifo_y     [FIFO_DEPTH];
    logic [31:0]        fifo_color [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               in_ready_int;
    logic               push;
    logic               pop;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic [31:0]        head_color;
    logic [25:0]        pix_index;
    logic [25:0]        pop_address;
    logic [25:0]        avm_address_q;
    logic [31:0]        avm_writedata_q;
    logic               avm_write_q;

    assign full         = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign in_ready_int = reset && !full;
    assign push         = bus.in_valid && in_ready_int;
    assign pop          = (state == IDLE) && (count != '0);

    assign head_x     = fifo_x[rd_ptr];
    assign head_y     = fifo_y[rd_ptr];
    assign head_color = fifo_color[rd_ptr];

    // All address arithmetic is deliberately 26 bits wide so it wraps modulo 2^26.
    assign pix_index   = 26'(head_y) * 26'(FB_WIDTH) + 26'(head_x);
    assign pop_address = {pix_index[23:0], 2'b00} + base_addr;

    assign bus.in_ready      = in_ready_int;
    assign bus.avm_address   = avm_address_q;
    assign bus.avm_writedata = avm_writedata_q;
    assign bus.avm_write     = avm_write_q;
    assign busy              = (count != '0) || (state != IDLE);

`ifdef CLIP_EN
    localparam logic [31:0] FB_WIDTH_U  = FB_WIDTH;
    localparam logic [31:0] FB_HEIGHT_U = FB_HEIGHT;
    logic head_out_of_range;

    assign head_out_of_range = (32'(head_x) >= FB_WIDTH_U) || (32'(head_y) >= FB_HEIGHT_U);
`else
    assign clipped_count = '0;
`endif

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_x[wr_ptr]     <= bus.in_x;
            fifo_y[wr_ptr]     <= bus.in_y;
            fifo_color[wr_ptr] <= bus.in_color;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            avm_write_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            pixels_written  <= '0;
`ifdef CLIP_EN
            clipped_count   <= '0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: ;
            endcase

            // The adapter reads the low half late, so address/data stay frozen until IDLE reloads them.
            case (state)
                IDLE: begin
                    if (count != '0) begin
`ifdef CLIP_EN
                        if (head_out_of_range) begin
                            if (clipped_count != 16'hFFFF) begin
                                clipped_count <= clipped_count + 16'd1;
                            end
                        end else
`endif
                        begin
                            avm_address_q   <= pop_address;
                            avm_writedata_q <= head_color;
                            avm_write_q     <= 1'b1;
                            state           <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!bus.avm_waitrequest) begin
                        avm_write_q <= 1'b0;
                        state       <= DRAIN_FIRST;
                    end
                end
                DRAIN_FIRST: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.avm_waitrequest) begin
                        pixels_written <= pixels_written + 32'd1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_write_master.sv
// tb_pixel_write_master: randomized stimulus for pixel_write_master checked against a queue-based
// model of expected framebuffer writes. Build with CLIP_EN defined to exercise clipping.
`timescale 1ns/1ps
module tb_pixel_write_master;
    localparam int FB_WIDTH   = 640;
    localparam int FB_HEIGHT  = 480;
    localparam int COORD_W    = 10;
    localparam int FIFO_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [25:0] base_addr = '0;
    logic        busy;
    logic [31:0] pixels_written;
    logic [15:0] clipped_count;

    pixel_write_master_if #(.COORD_W(COORD_W)) bus ();

    pixel_write_master #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .COORD_W   (COORD_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .base_addr     (base_addr),
        .busy          (busy),
        .pixels_written(pixels_written),
        .clipped_count (clipped_count)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          wait_mode = 0;
    int          stab_err = 0;
    int          exp_written = 0;
    int          exp_clipped = 0;
    logic [57:0] exp_q[$];
    logic [57:0] obs_q[$];
    logic        mon_valid = 1'b0;
    logic        prev_reset = 1'b0;
    logic        prev_write = 1'b0;
    logic [25:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    // Adapter model: waitrequest held low, held high, or random, changed just after each edge.
    always @(posedge clock) begin
        #1;
        case (wait_mode)
            0:       bus.avm_waitrequest = 1'b0;
            1:       bus.avm_waitrequest = 1'b1;
            default: bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Records accepted writes and flags address/data changes other than at a fresh write request.
    always @(negedge clock) begin
        if (mon_valid && prev_reset && !(bus.avm_write && !prev_write) &&
            (bus.avm_address !== prev_addr || bus.avm_writedata !== prev_data)) begin
            stab_err++;
        end
        if (reset && bus.avm_write === 1'b1 && bus.avm_waitrequest === 1'b0) begin
            obs_q.push_back({bus.avm_address, bus.avm_writedata});
        end
        prev_reset = reset;
        prev_write = bus.avm_write;
        prev_addr  = bus.avm_address;
        prev_data  = bus.avm_writedata;
        mon_valid  = 1'b1;
    end

    function automatic logic [25:0] ref_addr(input int x, input int y, input logic [25:0] base);
        longint lin;
        lin = (longint'(y) * FB_WIDTH + x) * 4 + base;
        return 26'(lin);
    endfunction

    task automatic model_push(input int x, input int y, input logic [31:0] c);
`ifdef CLIP_EN
        if (x >= FB_WIDTH || y >= FB_HEIGHT) begin
            exp_clipped++;
            return;
        end
`endif
        exp_q.push_back({ref_addr(x, y, base_addr), c});
        exp_written++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_pixel(input int x, input int y, input logic [31:0] c);
        bus.in_valid = 1'b1;
        bus.in_x     = COORD_W'(x);
        bus.in_y     = COORD_W'(y);
        bus.in_color = c;
        for (int i = 0; i < 500; i++) begin
            if (bus.in_ready === 1'b1) begin
                model_push(x, y, c);
                step();
                bus.in_valid = 1'b0;
                return;
            end
            step();
        end
        bus.in_valid = 1'b0;
        checks++;
        errors++;
        $display("[TB] FAIL push_timeout x=%0d y=%0d: in_ready never rose, required 1", x, y);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (busy === 1'b0) return;
            step();
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s_idle_timeout: busy=%b, required 0", name, busy);
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x     = COORD_W'(7);
        bus.in_y     = COORD_W'(9);
        bus.in_color = 32'h12345678;
        repeat (3) step();
        checks++; if (bus.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b, required 0", bus.avm_write); end
        checks++; if (bus.avm_address !== 26'd0) begin errors++; $display("[TB] FAIL reset_address: got %h, required 0", bus.avm_address); end
        checks++; if (bus.avm_writedata !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got %h, required 0", bus.avm_writedata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (pixels_written !== 32'd0) begin errors++; $display("[TB] FAIL reset_written: got %0d, required 0", pixels_written); end
        checks++; if (clipped_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_clipped: got %0d, required 0", clipped_count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_push: busy=%b, required 0", busy); end
    endtask

    task automatic test_single_pixel();
        wait_mode = 0;
        base_addr = '0;
        obs_q.delete();
        exp_q.delete();
        push_pixel(3, 2, 32'hDEADBEEF);
        checks++; if (bus.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL single_early_write: got %b, required 0", bus.avm_write); end
        step();
        checks++; if (bus.avm_write !== 1'b1) begin errors++; $display("[TB] FAIL single_write_latency: got %b, required 1", bus.avm_write); end
        checks++; if (bus.avm_address !== 26'd5132) begin errors++; $display("[TB] FAIL single_address: got %0d, required 5132", bus.avm_address); end
        checks++; if (bus.avm_writedata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_data: got %h, required deadbeef", bus.avm_writedata); end
        wait_idle("single");
        checks++; if (pixels_written !== 32'(exp_written)) begin errors++; $display("[TB] FAIL single_written: got %0d, required %0d", pixels_written, exp_written); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("[TB] FAIL single_write_count: got %0d, required 1", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        int xs[6];
        int ys[6];
        logic [31:0] cs[6];
        int idx;
        base_addr = 26'($urandom);
        obs_q.delete();
        exp_q.delete();
        stab_err = 0;
        for (int i = 0; i < 6; i++) begin
            xs[i] = $urandom_range(0, FB_WIDTH - 1);
            ys[i] = $urandom_range(0, FB_HEIGHT - 1);
            cs[i] = $urandom;
        end
        wait_mode = 1;
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (idx < 6) begin
                bus.in_valid = 1'b1;
                bus.in_x     = COORD_W'(xs[idx]);
                bus.in_y     = COORD_W'(ys[idx]);
                bus.in_color = cs[idx];
                if (bus.in_ready === 1'b1) begin
                    model_push(xs[idx], ys[idx], cs[idx]);
                    idx++;
                end
            end
            step();
        end
        bus.in_valid = 1'b0;
        checks++; if (idx != 5) begin errors++; $display("[TB] FAIL b2b_accepted: got %0d, required 5", idx); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready: got %b, required 0", bus.in_ready); end
        checks++; if (bus.avm_write !== 1'b1) begin errors++; $display("[TB] FAIL b2b_stalled_write: got %b, required 1", bus.avm_write); end
        wait_mode = 2;
        while (idx < 6) begin
            push_pixel(xs[idx], ys[idx], cs[idx]);
            idx++;
        end
        wait_idle("b2b");
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL b2b_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_write%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (stab_err != 0) begin errors++; $display("[TB] FAIL b2b_stability: got %0d changes, required 0", stab_err); end
        checks++; if (pixels_written !== 32'(exp_written)) begin errors++; $display("[TB] FAIL b2b_written: got %0d, required %0d", pixels_written, exp_written); end
    endtask

    task automatic test_addr_wrap();
        wait_mode = 0;
        base_addr = 26'h3FFFFFC;
        obs_q.delete();
        exp_q.delete();
        push_pixel(1, 0, 32'hA5A5_0001);
        wait_idle("wrap");
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("[TB] FAIL wrap_count: got %0d, required 1", obs_q.size());
        end else if (obs_q[0][57:32] !== 26'd0) begin
            errors++; $display("[TB] FAIL wrap_address: got %h, required 0", obs_q[0][57:32]);
        end
    endtask

    task automatic test_clip();
        int         first_addr;
        int         want_writes;
        wait_mode = 0;
        base_addr = '0;
        obs_q.delete();
        exp_q.delete();
        push_pixel(640, 5, 32'h1111_1111);
        push_pixel(0, 480, 32'h2222_2222);
        push_pixel(1, 1, 32'h3333_3333);
        wait_idle("clip");
`ifdef CLIP_EN
        want_writes = 1;
        first_addr  = 2564;
`else
        want_writes = 3;
        first_addr  = 15360;
`endif
        checks++; if (clipped_count !== 16'(exp_clipped)) begin errors++; $display("[TB] FAIL clip_count: got %0d, required %0d", clipped_count, exp_clipped); end
        checks++; if (obs_q.size() != want_writes) begin errors++; $display("[TB] FAIL clip_writes: got %0d, required %0d", obs_q.size(), want_writes); end
        checks++;
        if (obs_q.size() == 0 || obs_q[0][57:32] !== 26'(first_addr)) begin
            errors++; $display("[TB] FAIL clip_first_address: got %0d writes, required first address %0d", obs_q.size(), first_addr);
        end
        checks++; if (pixels_written !== 32'(exp_written)) begin errors++; $display("[TB] FAIL clip_written: got %0d, required %0d", pixels_written, exp_written); end
    endtask

    task automatic test_random();
        wait_mode = 2;
        base_addr = 26'($urandom);
        obs_q.delete();
        exp_q.delete();
        stab_err = 0;
        for (int i = 0; i < 24; i++) begin
            push_pixel($urandom_range(0, FB_WIDTH - 1), $urandom_range(0, FB_HEIGHT - 1), $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) step();
        end
        wait_idle("random");
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL random_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL random_write%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (stab_err != 0) begin errors++; $display("[TB] FAIL random_stability: got %0d changes, required 0", stab_err); end
        checks++; if (pixels_written !== 32'(exp_written)) begin errors++; $display("[TB] FAIL random_written: got %0d, required %0d", pixels_written, exp_written); end
    endtask

    task automatic test_reset_in_drain();
        bit seen;
        wait_mode = 0;
        base_addr = '0;
        push_pixel(10, 10, 32'hCAFE_0001);
        push_pixel(11, 10, 32'hCAFE_0002);
        push_pixel(12, 10, 32'hCAFE_0003);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (bus.avm_write === 1'b1 && bus.avm_waitrequest === 1'b0) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL drain_accept_timeout: no accepted write, required one"); end
        step();
        reset = 1'b0;
        step();
        checks++; if (bus.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL drain_reset_write: got %b, required 0", bus.avm_write); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drain_reset_busy: got %b, required 0", busy); end
        checks++; if (pixels_written !== 32'd0) begin errors++; $display("[TB] FAIL drain_reset_written: got %0d, required 0", pixels_written); end
        checks++; if (clipped_count !== 16'd0) begin errors++; $display("[TB] FAIL drain_reset_clipped: got %0d, required 0", clipped_count); end
        reset       = 1'b1;
        exp_written = 0;
        exp_clipped = 0;
        repeat (5) step();
        checks++; if (busy !== 1'b0 || bus.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL drain_fifo_empty: busy=%b write=%b, required 0 0", busy, bus.avm_write); end
        checks++; if (pixels_written !== 32'd0) begin errors++; $display("[TB] FAIL drain_post_written: got %0d, required 0", pixels_written); end
    endtask

    initial begin
        bus.in_valid        = 1'b0;
        bus.in_x            = '0;
        bus.in_y            = '0;
        bus.in_color        = '0;
        bus.avm_waitrequest = 1'b0;
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_addr_wrap();
        test_clip();
        test_random();
        test_reset_in_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
